// File: rtl/alu_pkg.sv
// Shared definitions for the byte-ALU opcode/data interface: opcodes,
// status bit positions, command record and the command-driver FSM states.
package alu_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_SUB    = 4'h3;
  localparam logic [3:0] OP_AND    = 4'h4;
  localparam logic [3:0] OP_OR     = 4'h5;
  localparam logic [3:0] OP_XOR    = 4'h6;
  localparam logic [3:0] OP_SHL    = 4'h7;
  localparam logic [3:0] OP_SHR    = 4'h8;
  localparam logic [3:0] OP_INC    = 4'h9;
  localparam logic [3:0] OP_DEC    = 4'hA;
  localparam logic [3:0] OP_NOT    = 4'hB;
  localparam logic [3:0] OP_MUL    = 4'hC;
  localparam logic [3:0] OP_DIV    = 4'hD;
  localparam logic [3:0] OP_MOD    = 4'hE;
  localparam logic [3:0] OP_STATUS = 4'hF;

  // Bit positions inside the ALU status byte
  localparam int ST_ZERO  = 0;
  localparam int ST_NEG   = 1;
  localparam int ST_CARRY = 2;

  localparam int CMD_W = 12;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] operand;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAP_ACC,
    S_CAP_STAT,
    S_RESP
  } drv_state_e;

  // The status-read opcode is reserved for the driver itself; a host
  // request for it becomes a NOP so every command still yields accum+status.
  function automatic logic [3:0] sanitize_op(input logic [3:0] op);
    return (op == OP_STATUS) ? OP_NOP : op;
  endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Bus bundle between host, command driver and ALU.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; valid, once raised, holds its payload stable until that edge, and
// ready may be asserted independently of valid.
interface alu_cmd_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [7:0] cmd_operand;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_accum;
  logic [2:0] rsp_status;
  logic [3:0] alu_opcode;
  logic [7:0] alu_data_in;
  logic [7:0] alu_data_out;

  // Command driver side
  modport slave (
    input  cmd_valid, cmd_opcode, cmd_operand, rsp_ready, alu_data_out,
    output cmd_ready, rsp_valid, rsp_accum, rsp_status, alu_opcode, alu_data_in
  );

  // Host + ALU side
  modport master (
    output cmd_valid, cmd_opcode, cmd_operand, rsp_ready, alu_data_out,
    input  cmd_ready, rsp_valid, rsp_accum, rsp_status, alu_opcode, alu_data_in
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Small synchronous FIFO holding queued host commands; head is read
// combinationally so the FSM can issue it in the same edge it pops.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic [W-1:0]   wr_data,
  input  logic           pop,
  output logic [W-1:0]   rd_data,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; no reset needed since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator for the byte ALU: queues host commands, issues each one followed
// by a status read, and returns {accum, status} per command.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_driver_if.slave  bus,
  output logic             busy,
  output drv_state_e       state_dbg,
  output logic [PTR_W:0]   fifo_count_dbg
);

  drv_state_e       state, state_n;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CMD_W-1:0] head_bits;
  cmd_t             head;

  logic [3:0] alu_opcode_q, alu_opcode_n;
  logic [7:0] alu_data_in_q, alu_data_in_n;
  logic [7:0] rsp_accum_q, rsp_accum_n;
  logic [2:0] rsp_status_q, rsp_status_n;
  logic       rsp_valid_q, rsp_valid_n;

  alu_cmd_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W), .W(CMD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.cmd_valid),
    .wr_data ({bus.cmd_opcode, bus.cmd_operand}),
    .pop     (fifo_pop),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count_dbg)
  );

  assign head            = head_bits;
  assign bus.cmd_ready   = !fifo_full;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_accum   = rsp_accum_q;
  assign bus.rsp_status  = rsp_status_q;
  assign bus.alu_opcode  = alu_opcode_q;
  assign bus.alu_data_in = alu_data_in_q;
  assign busy            = (state != S_IDLE) || !fifo_empty;
  assign state_dbg       = state;

  // State and registered ALU/response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      alu_opcode_q  <= OP_NOP;
      alu_data_in_q <= '0;
      rsp_accum_q   <= '0;
      rsp_status_q  <= '0;
      rsp_valid_q   <= 1'b0;
    end else begin
      state         <= state_n;
      alu_opcode_q  <= alu_opcode_n;
      alu_data_in_q <= alu_data_in_n;
      rsp_accum_q   <= rsp_accum_n;
      rsp_status_q  <= rsp_status_n;
      rsp_valid_q   <= rsp_valid_n;
    end
  end

  // Next state and next register values; the ALU sees NOP unless a state
  // explicitly issues something, so nothing executes while a response waits.
  always_comb begin
    state_n       = state;
    fifo_pop      = 1'b0;
    alu_opcode_n  = OP_NOP;
    alu_data_in_n = '0;
    rsp_accum_n   = rsp_accum_q;
    rsp_status_n  = rsp_status_q;
    rsp_valid_n   = rsp_valid_q;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          alu_opcode_n  = sanitize_op(head.opcode);
          alu_data_in_n = head.operand;
          state_n       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        alu_opcode_n = OP_STATUS;
        state_n      = S_CAP_ACC;
      end
      S_CAP_ACC: begin
        rsp_accum_n = bus.alu_data_out;
        state_n     = S_CAP_STAT;
      end
      S_CAP_STAT: begin
        rsp_status_n = {bus.alu_data_out[ST_CARRY], bus.alu_data_out[ST_NEG],
                        bus.alu_data_out[ST_ZERO]};
        rsp_valid_n  = 1'b1;
        state_n      = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_n = 1'b0;
          if (!fifo_empty) begin
            fifo_pop      = 1'b1;
            alu_opcode_n  = sanitize_op(head.opcode);
            alu_data_in_n = head.operand;
            state_n       = S_ISSUE;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: byte-ALU model, host driver tasks, response
// scoreboard, directed vector table plus multi-cycle corner sequences.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_cmd_driver_if bus();
  logic       busy;
  drv_state_e state_dbg;
  logic [2:0] fifo_count_dbg;

  alu_cmd_driver #(.DEPTH(4), .PTR_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .busy           (busy),
    .state_dbg      (state_dbg),
    .fifo_count_dbg (fifo_count_dbg)
  );

  // ---------------- ALU model ----------------
  logic [7:0] m_acc, m_dout;
  logic [2:0] m_flags;
  logic [8:0] m_res;

  function automatic logic [8:0] alu_exec(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      OP_LOAD: return {1'b0, b};
      OP_ADD:  return {1'b0, a} + {1'b0, b};
      OP_SUB:  return {(a < b), 8'(a - b)};
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_XOR:  return {1'b0, a ^ b};
      OP_MUL:  return {|p[15:8], p[7:0]};
      default: return {1'b0, a};
    endcase
  endfunction

  assign m_res = alu_exec(bus.alu_opcode, m_acc, bus.alu_data_in);
  assign bus.alu_data_out = m_dout;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc <= '0; m_flags <= '0; m_dout <= '0;
    end else if (bus.alu_opcode == OP_STATUS) begin
      m_dout <= {5'b0, m_flags};
    end else if (bus.alu_opcode inside {OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MUL}) begin
      m_acc   <= m_res[7:0];
      m_dout  <= m_res[7:0];
      m_flags <= {m_res[8], m_res[7], (m_res[7:0] == 8'h00)};
    end else begin
      m_dout <= m_acc;
    end
  end

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_rsp = 0;
  int          rsp_cyc[$];
  logic [3:0]  op_log[$];
  bit          log_en = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (log_en && bus.alu_opcode != OP_NOP) op_log.push_back(bus.alu_opcode);
      if (bus.rsp_valid && bus.rsp_ready) begin
        logic [10:0] e;
        n_rsp++;
        rsp_cyc.push_back(cyc);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rsp_unexpected: got accum=%02h status=%03b, required no response",
                   bus.rsp_accum, bus.rsp_status);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rsp_accum, bus.rsp_status} !== e) begin
            n_err++;
            $display("FAIL rsp_data #%0d: got accum=%02h status=%03b, required accum=%02h status=%03b",
                     n_rsp, bus.rsp_accum, bus.rsp_status, e[10:3], e[2:0]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [3:0] op, input logic [7:0] d);
    int g = 0;
    bus.cmd_valid   = 1'b1;
    bus.cmd_opcode  = op;
    bus.cmd_operand = d;
    @(negedge clk);
    while (!bus.cmd_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!bus.cmd_ready) begin
      n_cmp++; n_err++;
      $display("FAIL push_timeout: got cmd_ready=0 for %0d cycles, required 1", g);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic expect_rsp(input logic [7:0] acc, input logic [2:0] st);
    exp_q.push_back({acc, st});
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] d;
    logic [7:0] acc;
    logic [2:0] st;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_ops[$];
    int k;
    int rsp_before;
    int bad_vld, bad_acc, bad_st, bad_op, bad_rdy;

    tbl[0]  = '{4'h1, 8'h05, 8'h05, 3'b000};
    tbl[1]  = '{4'h2, 8'h03, 8'h08, 3'b000};
    tbl[2]  = '{4'h1, 8'h02, 8'h02, 3'b000};
    tbl[3]  = '{4'h3, 8'h03, 8'hFF, 3'b110};
    tbl[4]  = '{4'h1, 8'h10, 8'h10, 3'b000};
    tbl[5]  = '{4'hC, 8'h10, 8'h00, 3'b101};
    tbl[6]  = '{4'hF, 8'h00, 8'h00, 3'b101};
    tbl[7]  = '{4'h1, 8'h7F, 8'h7F, 3'b000};
    tbl[8]  = '{4'h2, 8'h01, 8'h80, 3'b010};
    tbl[9]  = '{4'h2, 8'h80, 8'h00, 3'b101};
    tbl[10] = '{4'h0, 8'h00, 8'h00, 3'b101};

    bus.cmd_valid   = 1'b0;
    bus.cmd_opcode  = '0;
    bus.cmd_operand = '0;
    bus.rsp_ready   = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid",   bus.rsp_valid, 0);
    check("rst_rsp_accum",   bus.rsp_accum, 0);
    check("rst_rsp_status",  bus.rsp_status, 0);
    check("rst_alu_opcode",  bus.alu_opcode, 0);
    check("rst_alu_data_in", bus.alu_data_in, 0);
    check("rst_busy",        busy, 0);
    check("rst_fifo_count",  fifo_count_dbg, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    check("post_rst_state",     state_dbg, S_IDLE);

    // Latency on the first table entry, then the rest streamed
    log_en = 1;
    push_cmd(tbl[0].op, tbl[0].d);
    expect_rsp(tbl[0].acc, tbl[0].st);
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("latency_edges", k, 4);
    wait_drain();
    for (int i = 1; i < 11; i++) begin
      push_cmd(tbl[i].op, tbl[i].d);
      expect_rsp(tbl[i].acc, tbl[i].st);
    end
    wait_drain();
    log_en = 0;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].op != OP_NOP && tbl[i].op != OP_STATUS) exp_ops.push_back(tbl[i].op);
      exp_ops.push_back(OP_STATUS);
    end
    check("op_log_len", op_log.size(), exp_ops.size());
    for (int i = 0; i < exp_ops.size() && i < op_log.size(); i++)
      check($sformatf("op_log[%0d]", i), op_log[i], exp_ops[i]);

    // Backpressure: 5 commands with the host stalled
    bus.rsp_ready = 1'b0;
    push_cmd(4'h1, 8'h11); expect_rsp(8'h11, 3'b000);
    push_cmd(4'h2, 8'h22); expect_rsp(8'h33, 3'b000);
    push_cmd(4'h3, 8'h03); expect_rsp(8'h30, 3'b000);
    push_cmd(4'h6, 8'hFF); expect_rsp(8'hCF, 3'b010);
    push_cmd(4'h2, 8'h31); expect_rsp(8'h00, 3'b101);
    @(negedge clk);
    check("bp_cmd_ready_full", bus.cmd_ready, 0);
    check("bp_fifo_count",     fifo_count_dbg, 4);
    bad_vld = 0; bad_acc = 0; bad_st = 0; bad_op = 0; bad_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b1)      bad_vld++;
      if (bus.rsp_accum !== 8'h11)     bad_acc++;
      if (bus.rsp_status !== 3'b000)   bad_st++;
      if (bus.alu_opcode !== OP_NOP)   bad_op++;
      if (bus.cmd_ready !== 1'b0)      bad_rdy++;
    end
    check("bp_valid_held_cycles_bad",  bad_vld, 0);
    check("bp_accum_stable_bad",       bad_acc, 0);
    check("bp_status_stable_bad",      bad_st, 0);
    check("bp_alu_opcode_nop_bad",     bad_op, 0);
    check("bp_cmd_ready_low_bad",      bad_rdy, 0);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_drain();

    // Reset during CAP_ACC of a queued burst
    rsp_before = n_rsp;
    push_cmd(4'h1, 8'hAA);
    push_cmd(4'h2, 8'h01);
    push_cmd(4'h2, 8'h01);
    k = 0;
    while (state_dbg != S_CAP_ACC && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("mid_rst_reached_cap_acc", state_dbg, S_CAP_ACC);
    rst = 1'b1;
    #1;
    check("mid_rst_rsp_valid",  bus.rsp_valid, 0);
    check("mid_rst_busy",       busy, 0);
    check("mid_rst_fifo_count", fifo_count_dbg, 0);
    check("mid_rst_alu_opcode", bus.alu_opcode, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_rst_rsp_valid", bus.rsp_valid, 0);
    check("after_rst_busy",      busy, 0);
    push_cmd(4'h2, 8'h07);
    expect_rsp(8'h07, 3'b000);
    wait_drain();
    check("mid_rst_rsp_count", n_rsp - rsp_before, 1);

    // Back-to-back stream through wrapping FIFO pointers
    rsp_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      d = 8'(i * 29);
      push_cmd(4'h1, d);
      expect_rsp(d, {1'b0, d[7], (d == 8'h00)});
    end
    wait_drain();
    check("stream_rsp_count", rsp_cyc.size(), 10);
    for (int i = 1; i < rsp_cyc.size(); i++)
      check($sformatf("stream_interval[%0d]", i), rsp_cyc[i] - rsp_cyc[i-1], 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
